fifo_rd_drain: RTL

Read-side drain engine for the asynchronous FIFO. It runs entirely in the read clock domain and pulls words from the FIFO read port whenever data is available. It absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer and presents the words as a valid/ready stream to downstream logic. This gives full-rate, loss-free, in-order reads under arbitrary downstream back-pressure.

---
 rtl/fifo_rd_drain_if.sv | 25 ++
 rtl/fifo_rd_drain.sv | 101 ++++++++++
 2 files changed

// File: rtl/fifo_rd_drain_if.sv
// Handshake bundle between the FIFO read port, the drain engine and the downstream stream.
// The master side is the drain engine; the slave side is the FIFO/downstream environment.
interface fifo_rd_drain_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  rd_avail;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  pop_count;

  modport master (
    input  rd_avail, rd_data, flush, out_ready,
    output rd_en, out_valid, out_data, pop_count
  );

  modport slave (
    output rd_avail, rd_data, flush, out_ready,
    input  rd_en, out_valid, out_data, pop_count
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: pulls FIFO words, hides the one-cycle read latency in a
// 2-entry skid buffer and presents them as an in-order valid/ready stream.
module fifo_rd_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  fifo_rd_drain_if.master   io_bus
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned SUM_W = 3;

  logic [OCC_W-1:0]      r_occ;
  logic                  r_inflight;
  logic                  r_armed;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [CNT_WIDTH-1:0]  r_pop_count;

  logic [OCC_W-1:0]      w_occ_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_tail_nxt;
  logic [CNT_WIDTH-1:0]  w_pop_count_nxt;
  logic [SUM_W-1:0]      w_committed;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_rd_en;

  // Read request: only when the word can be guaranteed a slot after this cycle's pop.
  // r_armed keeps Rd_en low until the first edge after reset release.
  always_comb begin
    w_pop       = (r_occ != OCC_W'(0)) && io_bus.out_ready;
    w_committed = SUM_W'(r_occ) + SUM_W'(r_inflight) - SUM_W'(w_pop);
    w_rd_en     = r_armed && io_bus.rd_avail && !io_bus.flush
                  && (w_committed < SUM_W'(2));
    w_wr        = r_inflight && !io_bus.flush;
  end

  // Skid buffer next state: tail fill, head shift on pop, flush empties.
  always_comb begin
    w_occ_nxt       = r_occ;
    w_head_nxt      = r_head;
    w_tail_nxt      = r_tail;
    w_pop_count_nxt = r_pop_count + CNT_WIDTH'(w_pop);

    case ({w_wr, w_pop})
      2'b10: begin
        if (r_occ == OCC_W'(0)) begin
          w_head_nxt = io_bus.rd_data;
        end else begin
          w_tail_nxt = io_bus.rd_data;
        end
        w_occ_nxt = r_occ + OCC_W'(1);
      end
      2'b01: begin
        w_head_nxt = r_tail;
        w_occ_nxt  = r_occ - OCC_W'(1);
      end
      2'b11: begin
        if (r_occ == OCC_W'(1)) begin
          w_head_nxt = io_bus.rd_data;
        end else begin
          w_head_nxt = r_tail;
          w_tail_nxt = io_bus.rd_data;
        end
      end
      default: begin
      end
    endcase

    if (io_bus.flush) begin
      w_occ_nxt = OCC_W'(0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ       <= OCC_W'(0);
      r_inflight  <= 1'b0;
      r_armed     <= 1'b0;
      r_head      <= DATA_WIDTH'(0);
      r_tail      <= DATA_WIDTH'(0);
      r_pop_count <= CNT_WIDTH'(0);
    end else begin
      r_occ       <= w_occ_nxt;
      r_inflight  <= w_rd_en;
      r_armed     <= 1'b1;
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_pop_count <= w_pop_count_nxt;
    end
  end

  assign io_bus.rd_en     = w_rd_en;
  assign io_bus.out_valid = (r_occ != OCC_W'(0));
  assign io_bus.out_data  = r_head;
  assign io_bus.pop_count = r_pop_count;

endmodule
